// File: rtl/avalon_wait_ram.sv
`default_nettype none
// ============================================================================
// Module      : avalon_wait_ram
// Description : Avalon-MM word RAM with byte enables, instruction preload port
//               and optional wait-state stall FSM (enabled by RAM_WAITSTATE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_wait_ram #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        inst_input,
  input  logic [7:0]  inst_addr,
  input  logic [31:0] instruction
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      inst_addr_ext;
  logic [IDX_W-1:0] bus_idx;
  logic [IDX_W-1:0] pre_idx;
  logic             bus_req;

  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;

  // Preload index is taken through the same ADDR_W slice so it wraps on depth.
  assign inst_addr_ext = {24'h0, inst_addr};
  assign bus_idx       = address[ADDR_W-1:2];
  assign pre_idx       = inst_addr_ext[ADDR_W-1:2];
  assign bus_req       = read | write;

  logic unused_bits;
  assign unused_bits = ^{address[31:ADDR_W], address[1:0],
                         inst_addr_ext[31:ADDR_W], inst_addr_ext[1:0]};

`ifdef RAM_WAITSTATE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The IDLE cycle counts as the first stall, so WAIT ends when the
  // counter is about to reach zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          cnt_d   = 4'(WAIT_CYCLES - 1);
          state_d = (WAIT_CYCLES == 1) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus_req) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1 || cnt_q == 4'd0) begin
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (inst_input) begin
      state_d = ST_IDLE;
    end
  end

  assign waitrequest = (bus_req && (state_q != ST_ACK)) || inst_input;
`else
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYCLES);
  assign waitrequest = inst_input;
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = bus_idx;
    mem_wdata = writedata;
    mem_be    = byteenable;
    if (inst_input) begin
      mem_we    = 1'b1;
      mem_idx   = pre_idx;
      mem_wdata = instruction;
      mem_be    = 4'hF;
    end else if (write && !waitrequest) begin
      mem_we = 1'b1;
    end
  end

  // Memory is never cleared; reset only blocks writes on its own edge.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign readdata = (read && !write && !waitrequest) ? mem_q[bus_idx] : 32'h0;

endmodule
`default_nettype wire
